// File: rtl/axi_address_decoder_aw_ord_if.sv
// AW-channel bundle for the ordered AW address decoder: master-side handshake,
// per-slave handshake, address map, outstanding tracking and error-path signals.
interface axi_address_decoder_aw_ord_if #(
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned N_INIT_PORT = 8,
    parameter int unsigned N_REGION    = 2,
    parameter int unsigned MAX_OUTST   = 8
);
    localparam int unsigned CNT_W = $clog2(MAX_OUTST + 1);

    logic                                                   awvalid_i;
    logic [ADDR_WIDTH-1:0]                                  awaddr_i;
    logic                                                   awready_o;
    logic [N_INIT_PORT-1:0]                                 awvalid_o;
    logic [N_INIT_PORT-1:0]                                 awready_i;
    logic [N_INIT_PORT-1:0]                                 dest_o;
    logic                                                   push_dest_o;
    logic [N_REGION-1:0][N_INIT_PORT-1:0][ADDR_WIDTH-1:0]   start_addr_i;
    logic [N_REGION-1:0][N_INIT_PORT-1:0][ADDR_WIDTH-1:0]   end_addr_i;
    logic [N_REGION-1:0][N_INIT_PORT-1:0]                   enable_region_i;
    logic [N_INIT_PORT-1:0]                                 connectivity_map_i;
    logic                                                   bdone_i;
    logic                                                   handle_error_o;
    logic                                                   err_wlast_i;
    logic                                                   err_req_o;
    logic                                                   err_gnt_i;
    logic [CNT_W-1:0]                                       outst_cnt_o;

    // Decoder side
    modport slave (
        input  awvalid_i, awaddr_i, awready_i, start_addr_i, end_addr_i,
               enable_region_i, connectivity_map_i, bdone_i, err_wlast_i, err_gnt_i,
        output awready_o, awvalid_o, dest_o, push_dest_o, handle_error_o, err_req_o,
               outst_cnt_o
    );

    // Environment side
    modport master (
        output awvalid_i, awaddr_i, awready_i, start_addr_i, end_addr_i,
               enable_region_i, connectivity_map_i, bdone_i, err_wlast_i, err_gnt_i,
        input  awready_o, awvalid_o, dest_o, push_dest_o, handle_error_o, err_req_o,
               outst_cnt_o
    );
endinterface

// File: rtl/axi_address_decoder_aw_ord.sv
// AW address decoder with write ordering: a new AW may only go to the slave that
// already holds outstanding writes. Unmapped addresses are absorbed by an error
// sequence (drain, sink W data, return error B).
// Optional macro AXI_AW_DEC_REG_EN registers the decode result in a one-entry stage.
module axi_address_decoder_aw_ord #(
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned N_INIT_PORT = 8,
    parameter int unsigned N_REGION    = 2,
    parameter int unsigned MAX_OUTST   = 8
) (
    input logic                       clk,
    input logic                       rst,
    axi_address_decoder_aw_ord_if.slave bus
);
    localparam int unsigned CNT_W = $clog2(MAX_OUTST + 1);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTST);

    typedef enum logic [1:0] {StOperative, StDrain, StErrWdata, StErrResp} state_e;

    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q;
    logic [N_INIT_PORT-1:0] last_dest_q;
    logic [N_INIT_PORT-1:0] match, dec_dest;
    logic                   dec_err, found;
    logic                   req_valid, req_err;
    logic [N_INIT_PORT-1:0] req_dest;
    logic                   stall, hs, dec;

    // Region match per port, then lowest-index priority to keep the result one-hot
    always_comb begin
        match    = '0;
        dec_dest = '0;
        found    = 1'b0;
        for (int p = 0; p < N_INIT_PORT; p++) begin
            for (int r = 0; r < N_REGION; r++) begin
                if (bus.enable_region_i[r][p] &&
                    bus.awaddr_i >= bus.start_addr_i[r][p] &&
                    bus.awaddr_i <= bus.end_addr_i[r][p]) begin
                    match[p] = 1'b1;
                end
            end
        end
        match = match & bus.connectivity_map_i;
        for (int p = 0; p < N_INIT_PORT; p++) begin
            if (match[p] && !found) begin
                dec_dest[p] = 1'b1;
                found       = 1'b1;
            end
        end
        dec_err = ~found;
    end

`ifdef AXI_AW_DEC_REG_EN
    logic                   stage_valid_q;
    logic [N_INIT_PORT-1:0] stage_dest_q;
    logic                   stage_err_q;
    logic                   stage_clear;

    // An errored request is consumed in the same cycle it is seen in StOperative
    assign stage_clear = hs | (state_q == StOperative && stage_valid_q && stage_err_q);

    // One-entry decode stage; the master holds awaddr_i until awready_o
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stage_valid_q <= 1'b0;
            stage_dest_q  <= '0;
            stage_err_q   <= 1'b0;
        end else if (stage_clear) begin
            stage_valid_q <= 1'b0;
        end else if (bus.awvalid_i && !stage_valid_q) begin
            stage_valid_q <= 1'b1;
            stage_dest_q  <= dec_dest;
            stage_err_q   <= dec_err;
        end
    end

    assign req_valid = stage_valid_q;
    assign req_dest  = stage_dest_q;
    assign req_err   = stage_err_q;
`else
    assign req_valid = bus.awvalid_i;
    assign req_dest  = dec_dest;
    assign req_err   = dec_err;
`endif

    assign bus.dest_o      = req_dest;
    assign bus.outst_cnt_o = cnt_q;

    // Ordering: switching slaves only once everything outstanding has completed
    assign stall = ((cnt_q != '0) && (req_dest != last_dest_q)) || (cnt_q == MAX_CNT);
    assign dec   = bus.bdone_i && (cnt_q != '0);

    // Next-state and outputs; everything forced low while rst is held
    always_comb begin
        state_d            = state_q;
        bus.awvalid_o      = '0;
        bus.awready_o      = 1'b0;
        bus.push_dest_o    = 1'b0;
        bus.handle_error_o = 1'b0;
        bus.err_req_o      = 1'b0;
        hs                 = 1'b0;
        if (!rst) begin
            case (state_q)
                StOperative: begin
                    if (req_valid) begin
                        if (req_err) begin
                            bus.awready_o = 1'b1;
                            state_d       = StDrain;
                        end else if (!stall) begin
                            bus.awvalid_o   = req_dest;
                            bus.awready_o   = |(req_dest & bus.awready_i);
                            hs              = bus.awready_o;
                            bus.push_dest_o = hs;
                        end
                    end
                end
                StDrain: begin
                    if (cnt_q == '0) state_d = StErrWdata;
                end
                StErrWdata: begin
                    bus.handle_error_o = 1'b1;
                    if (bus.err_wlast_i) state_d = StErrResp;
                end
                StErrResp: begin
                    bus.err_req_o = 1'b1;
                    if (bus.err_gnt_i) state_d = StOperative;
                end
                default: state_d = StOperative;
            endcase
        end
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= StOperative;
        else     state_q <= state_d;
    end

    // Outstanding counter; simultaneous accept and completion cancel out
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            case ({hs, dec})
                2'b10:   cnt_q <= cnt_q + CNT_W'(1);
                2'b01:   cnt_q <= cnt_q - CNT_W'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    // Destination of the most recent accepted non-error AW
    always_ff @(posedge clk or posedge rst) begin
        if (rst)     last_dest_q <= '0;
        else if (hs) last_dest_q <= req_dest;
    end
endmodule

// File: tb/tb_axi_address_decoder_aw_ord.sv
// Directed bench for axi_address_decoder_aw_ord: a table of single-cycle decode
// vectors followed by hand-written ordering, saturation, error and reset sequences.
module tb_axi_address_decoder_aw_ord;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    axi_address_decoder_aw_ord_if bus ();

    axi_address_decoder_aw_ord dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [7:0]  rdy;
        logic [7:0]  exp_avo;
        logic        exp_aro;
        logic [7:0]  exp_dest;
        logic        exp_push;
    } vec_t;

    vec_t vecs [11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_awvalid_o"}, 32'(bus.awvalid_o), 32'h0);
        check({tag, "_awready_o"}, 32'(bus.awready_o), 32'h0);
        check({tag, "_push"}, 32'(bus.push_dest_o), 32'h0);
        check({tag, "_handle_err"}, 32'(bus.handle_error_o), 32'h0);
        check({tag, "_err_req"}, 32'(bus.err_req_o), 32'h0);
        check({tag, "_cnt"}, 32'(bus.outst_cnt_o), 32'h0);
    endtask

    initial begin
        // addr, awready_i, awvalid_o, awready_o, dest_o, push_dest_o
        vecs[0]  = '{32'h1800, 8'h00, 8'h04, 1'b0, 8'h04, 1'b0};
        vecs[1]  = '{32'h1800, 8'h04, 8'h04, 1'b1, 8'h04, 1'b1};
        vecs[2]  = '{32'h1000, 8'hFB, 8'h04, 1'b0, 8'h04, 1'b0};
        vecs[3]  = '{32'h1FFF, 8'h04, 8'h04, 1'b1, 8'h04, 1'b1};
        vecs[4]  = '{32'h2000, 8'hFF, 8'h00, 1'b1, 8'h00, 1'b0};
        vecs[5]  = '{32'h0FFF, 8'hFF, 8'h00, 1'b1, 8'h00, 1'b0};
        vecs[6]  = '{32'h4000, 8'h0A, 8'h02, 1'b1, 8'h02, 1'b1};
        vecs[7]  = '{32'h3800, 8'h08, 8'h08, 1'b1, 8'h08, 1'b1};
        vecs[8]  = '{32'h6800, 8'hFF, 8'h00, 1'b1, 8'h00, 1'b0};
        vecs[9]  = '{32'h7000, 8'hFF, 8'h00, 1'b1, 8'h00, 1'b0};
        vecs[10] = '{32'h5800, 8'h00, 8'h20, 1'b0, 8'h20, 1'b0};

        bus.awvalid_i          = 1'b0;
        bus.awaddr_i           = '0;
        bus.awready_i          = '0;
        bus.bdone_i            = 1'b0;
        bus.err_wlast_i        = 1'b0;
        bus.err_gnt_i          = 1'b0;
        bus.start_addr_i       = '0;
        bus.end_addr_i         = '0;
        bus.enable_region_i    = '0;
        // Port 6 mapped but unreachable; port 4 mapped but disabled
        bus.connectivity_map_i = 8'hBF;
        bus.start_addr_i[0][2] = 32'h1000; bus.end_addr_i[0][2] = 32'h1FFF;
        bus.enable_region_i[0][2] = 1'b1;
        bus.start_addr_i[0][1] = 32'h4000; bus.end_addr_i[0][1] = 32'h4FFF;
        bus.enable_region_i[0][1] = 1'b1;
        bus.start_addr_i[1][3] = 32'h3000; bus.end_addr_i[1][3] = 32'h4FFF;
        bus.enable_region_i[1][3] = 1'b1;
        bus.start_addr_i[0][5] = 32'h5000; bus.end_addr_i[0][5] = 32'h5FFF;
        bus.enable_region_i[0][5] = 1'b1;
        bus.start_addr_i[1][6] = 32'h6000; bus.end_addr_i[1][6] = 32'h6FFF;
        bus.enable_region_i[1][6] = 1'b1;
        bus.start_addr_i[0][4] = 32'h7000; bus.end_addr_i[0][4] = 32'h7FFF;

        // Reset: outputs held low even with a valid, ready request present
        bus.awvalid_i = 1'b1; bus.awaddr_i = 32'h1800; bus.awready_i = 8'h04;
        tick(); tick();
        check_idle_outputs("reset");
        bus.awvalid_i = 1'b0; bus.awready_i = '0;
        rst = 1'b0;
        tick();

        // Decode table; request dropped before each edge so no state changes
        for (int i = 0; i < 11; i++) begin
            bus.awvalid_i = 1'b1;
            bus.awaddr_i  = vecs[i].addr;
            bus.awready_i = vecs[i].rdy;
            #1;
            check($sformatf("vec%0d_awvalid_o", i), 32'(bus.awvalid_o), 32'(vecs[i].exp_avo));
            check($sformatf("vec%0d_awready_o", i), 32'(bus.awready_o), 32'(vecs[i].exp_aro));
            check($sformatf("vec%0d_dest_o", i), 32'(bus.dest_o), 32'(vecs[i].exp_dest));
            check($sformatf("vec%0d_push", i), 32'(bus.push_dest_o), 32'(vecs[i].exp_push));
            bus.awvalid_i = 1'b0;
            bus.awready_i = '0;
            tick();
        end
        check("table_cnt_still_0", 32'(bus.outst_cnt_o), 32'h0);

        // Two writes to port 2, then a write to port 5 must wait for both B's
        bus.awvalid_i = 1'b1; bus.awaddr_i = 32'h1800; bus.awready_i = 8'h04;
        #1;
        check("p2_awvalid_o", 32'(bus.awvalid_o), 32'h04);
        check("p2_awready_o", 32'(bus.awready_o), 32'h1);
        check("p2_push", 32'(bus.push_dest_o), 32'h1);
        tick();
        check("p2_cnt_1", 32'(bus.outst_cnt_o), 32'h1);
        tick();
        check("p2_cnt_2", 32'(bus.outst_cnt_o), 32'h2);
        bus.awaddr_i = 32'h5800; bus.awready_i = 8'h20;
        #1;
        check("p5_stall_awvalid_o", 32'(bus.awvalid_o), 32'h0);
        check("p5_stall_awready_o", 32'(bus.awready_o), 32'h0);
        check("p5_stall_push", 32'(bus.push_dest_o), 32'h0);
        bus.bdone_i = 1'b1; tick(); bus.bdone_i = 1'b0;
        #1;
        check("p5_after_b1_cnt", 32'(bus.outst_cnt_o), 32'h1);
        check("p5_after_b1_stall", 32'(bus.awvalid_o), 32'h0);
        bus.bdone_i = 1'b1; tick(); bus.bdone_i = 1'b0;
        #1;
        check("p5_after_b2_cnt", 32'(bus.outst_cnt_o), 32'h0);
        check("p5_issue_awvalid_o", 32'(bus.awvalid_o), 32'h20);
        check("p5_issue_awready_o", 32'(bus.awready_o), 32'h1);
        tick();
        check("p5_cnt_1", 32'(bus.outst_cnt_o), 32'h1);

        // Fill to the outstanding limit on the same destination
        repeat (7) tick();
        check("max_cnt", 32'(bus.outst_cnt_o), 32'h8);
        check("max_stall_awvalid_o", 32'(bus.awvalid_o), 32'h0);
        check("max_stall_awready_o", 32'(bus.awready_o), 32'h0);
        bus.bdone_i = 1'b1; tick(); bus.bdone_i = 1'b0;
        #1;
        check("max_minus1_cnt", 32'(bus.outst_cnt_o), 32'h7);
        check("max_minus1_awready_o", 32'(bus.awready_o), 32'h1);
        bus.bdone_i = 1'b1; tick(); bus.bdone_i = 1'b0;
        bus.awvalid_i = 1'b0; bus.awready_i = '0;
        #1;
        check("hs_and_b_cnt_same", 32'(bus.outst_cnt_o), 32'h7);
        repeat (7) begin
            bus.bdone_i = 1'b1; tick(); bus.bdone_i = 1'b0;
        end
        check("drained_cnt", 32'(bus.outst_cnt_o), 32'h0);
        bus.bdone_i = 1'b1; tick(); bus.bdone_i = 1'b0;
        check("b_at_zero_ignored", 32'(bus.outst_cnt_o), 32'h0);

        // Error sequence with one write still outstanding
        bus.awvalid_i = 1'b1; bus.awaddr_i = 32'h1800; bus.awready_i = 8'h04;
        tick();
        bus.awaddr_i = 32'hF000; bus.awready_i = '0;
        #1;
        check("err_accept_awready_o", 32'(bus.awready_o), 32'h1);
        check("err_accept_awvalid_o", 32'(bus.awvalid_o), 32'h0);
        check("err_accept_push", 32'(bus.push_dest_o), 32'h0);
        check("err_accept_dest_o", 32'(bus.dest_o), 32'h0);
        tick();
        bus.awaddr_i = 32'h1800; bus.awready_i = 8'h04;
        #1;
        check("drain_awready_o", 32'(bus.awready_o), 32'h0);
        check("drain_awvalid_o", 32'(bus.awvalid_o), 32'h0);
        check("drain_cnt", 32'(bus.outst_cnt_o), 32'h1);
        bus.awvalid_i = 1'b0; bus.awready_i = '0;
        tick();
        check("drain_hold_handle_err", 32'(bus.handle_error_o), 32'h0);
        bus.bdone_i = 1'b1; tick(); bus.bdone_i = 1'b0;
        #1;
        check("drain_cnt_0", 32'(bus.outst_cnt_o), 32'h0);
        check("drain_last_handle_err", 32'(bus.handle_error_o), 32'h0);
        tick();
        check("wdata_handle_err", 32'(bus.handle_error_o), 32'h1);
        check("wdata_err_req", 32'(bus.err_req_o), 32'h0);
        tick();
        check("wdata_hold_handle_err", 32'(bus.handle_error_o), 32'h1);
        bus.err_wlast_i = 1'b1; tick(); bus.err_wlast_i = 1'b0;
        #1;
        check("resp_handle_err", 32'(bus.handle_error_o), 32'h0);
        check("resp_err_req", 32'(bus.err_req_o), 32'h1);
        tick();
        check("resp_hold_err_req", 32'(bus.err_req_o), 32'h1);
        bus.err_gnt_i = 1'b1; tick(); bus.err_gnt_i = 1'b0;
        #1;
        check("back_err_req", 32'(bus.err_req_o), 32'h0);
        bus.awvalid_i = 1'b1; bus.awaddr_i = 32'h1800; bus.awready_i = '0;
        #1;
        check("back_operative_awvalid_o", 32'(bus.awvalid_o), 32'h04);
        bus.awvalid_i = 1'b0;
        tick();

        // Reset in the middle of the error sequence abandons it
        bus.awvalid_i = 1'b1; bus.awaddr_i = 32'hF000;
        tick();
        bus.awvalid_i = 1'b0;
        tick();
        check("pre_rst_handle_err", 32'(bus.handle_error_o), 32'h1);
        bus.awvalid_i = 1'b1; bus.awaddr_i = 32'h1800; bus.awready_i = 8'h04;
        rst = 1'b1;
        #1;
        check_idle_outputs("midrst");
        tick();
        rst = 1'b0;
        bus.awvalid_i = 1'b0; bus.awready_i = '0;
        bus.err_wlast_i = 1'b1; tick(); bus.err_wlast_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("post_rst_err_req_%0d", i), 32'(bus.err_req_o), 32'h0);
            check($sformatf("post_rst_handle_err_%0d", i), 32'(bus.handle_error_o), 32'h0);
            tick();
        end
        bus.awvalid_i = 1'b1; bus.awaddr_i = 32'h1800;
        #1;
        check("post_rst_operative", 32'(bus.awvalid_o), 32'h04);
        bus.awvalid_i = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
